// File: rtl/enc_pkg.sv
// Shared types for the one-hot to dual-rail encoder: FSM states, the token
// classification result, and the one-hot index helper.
package enc_pkg;

    typedef enum logic [1:0] {
        NUL  = 2'd0,
        DATA = 2'd1,
        RTZ  = 2'd2
    } enc_state_t;

    localparam int ERR_CNT_W = 8;
    localparam int MAX_SIZE  = 5;
    localparam int MAX_IN    = 2 ** MAX_SIZE;

    typedef struct packed {
        logic [MAX_SIZE-1:0] idx;
        logic                valid;
        logic                multi;
    } onehot_t;

    // Classifies a token: valid = exactly one bit set, multi = two or more set.
    function automatic onehot_t onehot_idx(input logic [MAX_IN-1:0] v);
        onehot_t     r;
        int unsigned n;
        r = '0;
        n = 0;
        for (int i = 0; i < MAX_IN; i++) begin
            if (v[i]) begin
                n++;
                r.idx = MAX_SIZE'(i);
            end
        end
        r.valid = (n == 1);
        r.multi = (n > 1);
        return r;
    endfunction

endpackage

// File: rtl/dualrail_skid.sv
// One-entry skid register holding the index of a token that arrived while
// the output side was busy.
module dualrail_skid
    import enc_pkg::*;
#(
    parameter int SIZE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_drain,
    input  logic [SIZE-1:0] i_idx,
    output logic            o_full,
    output logic [SIZE-1:0] o_idx
);

    logic            r_full;
    logic [SIZE-1:0] r_idx;

    // A load on the same edge as a drain keeps the entry occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_idx <= i_idx;
        end
    end

    assign o_full = r_full;
    assign o_idx  = r_idx;

endmodule

// File: rtl/encoder_4bit_dualrail.sv
// One-hot token to dual-rail codeword encoder with four-phase RTZ handshake
// and one-entry skid. Optional event counter enabled by ENC_ERR_COUNT_EN.
module encoder_4bit_dualrail
    import enc_pkg::*;
#(
    parameter int SIZE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2**SIZE-1:0]    in,
    input  logic                  ack,
    output logic [SIZE-1:0][1:0]  out,
    output logic                  busy,
    output logic                  err,
    output logic                  ovf,
    output logic                  warn,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    function automatic logic [SIZE-1:0][1:0] f_encode(input logic [SIZE-1:0] k);
        logic [SIZE-1:0][1:0] r;
        for (int b = 0; b < SIZE; b++) begin
            r[b] = {~k[b], k[b]};
        end
        return r;
    endfunction

    enc_state_t           r_state;
    logic [SIZE-1:0][1:0] r_out;
    logic                 r_err;
    logic                 r_ovf;
    logic                 r_warn;

    onehot_t              w_cls;
    logic [MAX_IN-1:0]    w_in_ext;
    logic [SIZE-1:0]      w_idx;
    logic                 w_skid_full;
    logic [SIZE-1:0]      w_skid_idx;
    logic                 w_can_load;
    logic                 w_take_in;
    logic                 w_skid_drain;
    logic                 w_skid_load;
    logic                 w_drop;
    logic                 w_src_vld;
    logic [SIZE-1:0]      w_src_idx;

    assign w_in_ext = MAX_IN'(in);
    assign w_cls    = onehot_idx(w_in_ext);
    assign w_idx    = w_cls.idx[SIZE-1:0];

    if (SIZE < MAX_SIZE) begin : g_idx_pad
        logic w_unused_hi;
        assign w_unused_hi = ^w_cls.idx[MAX_SIZE-1:SIZE];
    end

    // The output side accepts a new token in NUL, or in RTZ once ack has fallen.
    assign w_can_load   = (r_state == NUL) || ((r_state == RTZ) && !ack);
    assign w_skid_drain = w_can_load && w_skid_full;
    assign w_take_in    = w_can_load && !w_skid_full;
    assign w_skid_load  = w_cls.valid && !w_take_in && (!w_skid_full || w_skid_drain);
    assign w_drop       = w_cls.valid && !w_take_in && w_skid_full && !w_skid_drain;
    assign w_src_vld    = w_skid_full || w_cls.valid;
    assign w_src_idx    = w_skid_full ? w_skid_idx : w_idx;

    dualrail_skid #(.SIZE(SIZE)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_idx   (w_idx),
        .o_full  (w_skid_full),
        .o_idx   (w_skid_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= NUL;
            r_out   <= '0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            r_warn  <= 1'b0;
        end else begin
            r_err  <= w_cls.multi;
            r_ovf  <= w_drop;
            r_warn <= r_warn | r_err | r_ovf;
            case (r_state)
                NUL: begin
                    if (w_src_vld) begin
                        r_out   <= f_encode(w_src_idx);
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (ack) begin
                        r_out   <= '0;
                        r_state <= RTZ;
                    end
                end
                RTZ: begin
                    if (!ack) begin
                        if (w_src_vld) begin
                            r_out   <= f_encode(w_src_idx);
                            r_state <= DATA;
                        end else begin
                            r_state <= NUL;
                        end
                    end
                end
                default: begin
                    r_out   <= '0;
                    r_state <= NUL;
                end
            endcase
        end
    end

`ifdef ENC_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if ((r_err || r_ovf) && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

    assign out  = r_out;
    assign busy = w_skid_full;
    assign err  = r_err;
    assign ovf  = r_ovf;
    assign warn = r_warn;

endmodule
